// File: rtl/cmi_xfer_seq.sv
// CMI transfer sequencer: arbitration, command cycle, MDR data strobes and stall.
// Optional no-response timeout is enabled by defining CMI_TIMEOUT_EN.
module cmi_xfer_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       b_clk_l,
  input  logic       reset_l,
  input  logic       req_read_h,
  input  logic       req_write_h,
  input  logic       req_quad_h,
  input  logic       cmi_grant_h,
  input  logic       cmi_wait_h,
  input  logic       cmi_rd_valid_h,
  input  logic       cmi_err_h,
  output logic       cmi_req_h,
  output logic       cmi_cmd_valid_h,
  output logic       cmi_cmd_write_h,
  output logic       cmi_cmd_quad_h,
  output logic       ena_cmi_l,
  output logic       snapshot_cmi_l,
  output logic       mem_stall_h,
  output logic       xfer_done_h,
  output logic       xfer_err_h,
  output logic [1:0] err_code_h
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_CMD,
    S_WDATA,
    S_RWAIT,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [1:0] CODE_BUS = 2'b01;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("cmi_xfer_seq: TIMEOUT must be within 1..255");
  end

  state_e     state_q, state_d;
  logic       dir_q, dir_d;
  logic       quad_q, quad_d;
  logic       lw_q, lw_d;
  logic [1:0] err_code_q, err_code_d;

`ifdef CMI_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
  localparam logic [1:0] CODE_TMO  = 2'b10;

  logic [7:0] tmo_q, tmo_d;
  logic [7:0] tmo_inc;
  logic       tmo_hit;

  // Fault on the cycle the count would reach TIMEOUT, so exactly TIMEOUT idle cycles are spent.
  assign tmo_inc = tmo_q + 8'd1;
  assign tmo_hit = (tmo_inc == TMO_LIMIT);
`endif

  always_ff @(posedge b_clk_l) begin
    if (!reset_l) begin
      state_q    <= S_IDLE;
      dir_q      <= 1'b0;
      quad_q     <= 1'b0;
      lw_q       <= 1'b0;
      err_code_q <= '0;
`ifdef CMI_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      quad_q     <= quad_d;
      lw_q       <= lw_d;
      err_code_q <= err_code_d;
`ifdef CMI_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Next-state logic; tmo defaults to clear so every state entry restarts the count.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    quad_d     = quad_q;
    lw_d       = lw_q;
    err_code_d = err_code_q;
`ifdef CMI_TIMEOUT_EN
    tmo_d      = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        lw_d = 1'b0;
        if (req_write_h || req_read_h) begin
          state_d = S_ARB;
          dir_d   = req_write_h;
          quad_d  = req_quad_h;
        end
      end
      S_ARB: begin
        if (cmi_grant_h) begin
          state_d = S_CMD;
        end
`ifdef CMI_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d    = S_ERR;
          err_code_d = CODE_TMO;
        end else begin
          tmo_d = tmo_inc;
        end
`endif
      end
      S_CMD: begin
        if (cmi_err_h) begin
          state_d    = S_ERR;
          err_code_d = CODE_BUS;
        end else begin
          state_d = dir_q ? S_WDATA : S_RWAIT;
        end
      end
      S_WDATA: begin
        if (cmi_err_h) begin
          state_d    = S_ERR;
          err_code_d = CODE_BUS;
        end else if (!cmi_wait_h) begin
          if (lw_q == quad_q) begin
            state_d = S_DONE;
          end else begin
            lw_d = 1'b1;
          end
        end
      end
      S_RWAIT: begin
        if (cmi_err_h) begin
          state_d    = S_ERR;
          err_code_d = CODE_BUS;
        end else if (cmi_rd_valid_h) begin
          if (lw_q == quad_q) begin
            state_d = S_DONE;
          end else begin
            lw_d = 1'b1;
          end
        end
`ifdef CMI_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d    = S_ERR;
          err_code_d = CODE_TMO;
        end else begin
          tmo_d = tmo_inc;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmi_req_h       = (state_q == S_ARB);
    cmi_cmd_valid_h = (state_q == S_CMD);
    cmi_cmd_write_h = dir_q;
    cmi_cmd_quad_h  = quad_q;
    ena_cmi_l       = (state_q != S_WDATA);
    // A bus error in the same cycle as read data suppresses the capture.
    snapshot_cmi_l  = !((state_q == S_RWAIT) && cmi_rd_valid_h && !cmi_err_h);
    mem_stall_h     = ((state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR)) ||
                      ((state_q == S_IDLE) && (req_read_h || req_write_h));
    xfer_done_h     = (state_q == S_DONE);
    xfer_err_h      = (state_q == S_ERR);
    err_code_h      = err_code_q;
  end

endmodule

// File: tb/tb_cmi_xfer_seq.sv
// Bench for cmi_xfer_seq: each transfer is described by a schedule (grant delay,
// per-longword wait/gap counts, fault position) from which expected outputs follow.
module tb_cmi_xfer_seq;
`ifdef CMI_TIMEOUT_EN
  localparam int unsigned TB_TMO = 4;
`else
  localparam int unsigned TB_TMO = 255;
`endif

  logic       b_clk_l = 1'b0;
  logic       reset_l;
  logic       req_read_h, req_write_h, req_quad_h;
  logic       cmi_grant_h, cmi_wait_h, cmi_rd_valid_h, cmi_err_h;
  logic       cmi_req_h, cmi_cmd_valid_h, cmi_cmd_write_h, cmi_cmd_quad_h;
  logic       ena_cmi_l, snapshot_cmi_l, mem_stall_h, xfer_done_h, xfer_err_h;
  logic [1:0] err_code_h;

  int checks = 0;
  int errors = 0;

  // Expected latched attributes of the most recently accepted transfer and last fault code.
  logic       m_dir, m_quad;
  logic [1:0] m_code;

  always #5 b_clk_l = ~b_clk_l;

  cmi_xfer_seq #(.TIMEOUT(TB_TMO)) dut (
    .b_clk_l        (b_clk_l),
    .reset_l        (reset_l),
    .req_read_h     (req_read_h),
    .req_write_h    (req_write_h),
    .req_quad_h     (req_quad_h),
    .cmi_grant_h    (cmi_grant_h),
    .cmi_wait_h     (cmi_wait_h),
    .cmi_rd_valid_h (cmi_rd_valid_h),
    .cmi_err_h      (cmi_err_h),
    .cmi_req_h      (cmi_req_h),
    .cmi_cmd_valid_h(cmi_cmd_valid_h),
    .cmi_cmd_write_h(cmi_cmd_write_h),
    .cmi_cmd_quad_h (cmi_cmd_quad_h),
    .ena_cmi_l      (ena_cmi_l),
    .snapshot_cmi_l (snapshot_cmi_l),
    .mem_stall_h    (mem_stall_h),
    .xfer_done_h    (xfer_done_h),
    .xfer_err_h     (xfer_err_h),
    .err_code_h     (err_code_h)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [10:0] ev(input logic req, input logic cv, input logic ena_l,
                                     input logic snap_l, input logic stall, input logic done,
                                     input logic err);
    return {req, cv, m_dir, m_quad, ena_l, snap_l, stall, done, err, m_code};
  endfunction

  // Compare all outputs mid-cycle, then advance to just after the next rising edge.
  task automatic tick(input string tag, input logic [10:0] exp_v);
    logic [10:0] obs;
    @(negedge b_clk_l);
    obs = {cmi_req_h, cmi_cmd_valid_h, cmi_cmd_write_h, cmi_cmd_quad_h, ena_cmi_l,
           snapshot_cmi_l, mem_stall_h, xfer_done_h, xfer_err_h, err_code_h};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %b expected %b (req,cv,wr,quad,ena_l,snap_l,stall,done,err,code)",
             tag, obs, exp_v);
    end
    @(posedge b_clk_l);
    #1;
  endtask

  task automatic noise();
    cmi_grant_h    = 1'($urandom);
    cmi_wait_h     = 1'($urandom);
    cmi_rd_valid_h = 1'($urandom);
    cmi_err_h      = 1'($urandom);
  endtask

  task automatic noise_req();
    req_write_h = 1'($urandom);
    req_read_h  = 1'($urandom);
    req_quad_h  = 1'($urandom);
  endtask

  // g: ungranted ARB cycles; gap0/gap1: wait (write) or idle (read) cycles before each
  // longword; err_pos: index of the cycle after ARB (0 = CMD) carrying cmi_err_h, -1 = none.
  task automatic run_xfer(input logic wr, input logic rd, input logic q, input int g,
                          input int gap0, input int gap1, input int err_pos, input string nm);
    int  pos;
    int  n;
    bit  failed;
    bit  last;
    noise();
    req_write_h = wr;
    req_read_h  = rd;
    req_quad_h  = q;
    tick({nm, "/req"}, ev(0, 0, 1, 1, 1, 0, 0));
    m_dir  = wr;
    m_quad = q;
    for (int i = 0; i <= g; i++) begin
      noise();
      noise_req();
      cmi_grant_h = (i == g);
      tick({nm, "/arb"}, ev(1, 0, 1, 1, 1, 0, 0));
    end
    noise();
    noise_req();
    cmi_err_h = (err_pos == 0);
    failed = (err_pos == 0);
    tick({nm, "/cmd"}, ev(0, 1, 1, 1, 1, 0, 0));
    pos = 1;
    for (int lwi = 0; lwi <= int'(q) && !failed; lwi++) begin
      n = (lwi == 0) ? gap0 : gap1;
      for (int k = 0; k <= n && !failed; k++) begin
        last = (k == n);
        noise();
        noise_req();
        cmi_err_h = (pos == err_pos);
        failed = (pos == err_pos);
        if (wr) begin
          cmi_wait_h = !last;
          tick({nm, "/wdata"}, ev(0, 0, 0, 1, 1, 0, 0));
        end else begin
          cmi_rd_valid_h = last;
          tick({nm, "/rwait"}, ev(0, 0, 1, !(last && !failed), 1, 0, 0));
        end
        pos++;
      end
    end
    noise();
    noise_req();
    if (failed) begin
      m_code = 2'b01;
      tick({nm, "/err"}, ev(0, 0, 1, 1, 0, 0, 1));
    end else begin
      tick({nm, "/done"}, ev(0, 0, 1, 1, 0, 1, 0));
    end
    noise();
    req_write_h = 1'b0;
    req_read_h  = 1'b0;
    tick({nm, "/idle"}, ev(0, 0, 1, 1, 0, 0, 0));
  endtask

  task automatic quiet();
    req_write_h = 0; req_read_h = 0; req_quad_h = 0;
    cmi_grant_h = 0; cmi_wait_h = 0; cmi_rd_valid_h = 0; cmi_err_h = 0;
  endtask

  initial begin
    int kind;
    int ep;
    reset_l = 1'b0;
    quiet();
    m_dir  = 1'b0;
    m_quad = 1'b0;
    m_code = 2'b00;
    @(posedge b_clk_l);
    #1;
    tick("reset", ev(0, 0, 1, 1, 0, 0, 0));
    reset_l = 1'b1;
    tick("post_reset", ev(0, 0, 1, 1, 0, 0, 0));

    run_xfer(1, 0, 0, 0, 0, 0, -1, "wr_single");
    run_xfer(1, 0, 1, 0, 3, 0, -1, "wr_quad_wait");
    run_xfer(0, 1, 1, 0, 1, 3, -1, "rd_quad");
    run_xfer(0, 1, 0, 0, 0, 0, 1, "rd_err_valid");
    run_xfer(1, 1, 0, 1, 0, 0, -1, "wr_rd_both");
    run_xfer(1, 0, 1, 2, 1, 1, 2, "wr_err_wait");
    run_xfer(0, 1, 1, 1, 0, 2, 0, "cmd_err");

`ifdef CMI_TIMEOUT_EN
    quiet();
    req_read_h = 1'b1;
    tick("tmo/req", ev(0, 0, 1, 1, 1, 0, 0));
    m_dir  = 1'b0;
    m_quad = 1'b0;
    req_read_h  = 1'b0;
    cmi_grant_h = 1'b1;
    tick("tmo/arb", ev(1, 0, 1, 1, 1, 0, 0));
    cmi_grant_h = 1'b0;
    tick("tmo/cmd", ev(0, 1, 1, 1, 1, 0, 0));
    for (int i = 0; i < 4; i++) tick("tmo/rwait", ev(0, 0, 1, 1, 1, 0, 0));
    m_code = 2'b10;
    tick("tmo/err", ev(0, 0, 1, 1, 0, 0, 1));
    tick("tmo/idle", ev(0, 0, 1, 1, 0, 0, 0));
`else
    run_xfer(0, 1, 0, 0, 1000, 0, -1, "no_tmo");
`endif

    quiet();
    req_write_h = 1'b1;
    req_quad_h  = 1'b1;
    tick("rst/req", ev(0, 0, 1, 1, 1, 0, 0));
    m_dir  = 1'b1;
    m_quad = 1'b1;
    req_write_h = 1'b0;
    cmi_grant_h = 1'b1;
    tick("rst/arb", ev(1, 0, 1, 1, 1, 0, 0));
    cmi_grant_h = 1'b0;
    tick("rst/cmd", ev(0, 1, 1, 1, 1, 0, 0));
    cmi_wait_h = 1'b1;
    tick("rst/wdata", ev(0, 0, 0, 1, 1, 0, 0));
    reset_l = 1'b0;
    tick("rst/wdata_hold", ev(0, 0, 0, 1, 1, 0, 0));
    m_dir  = 1'b0;
    m_quad = 1'b0;
    m_code = 2'b00;
    cmi_wait_h = 1'b0;
    tick("rst/reset", ev(0, 0, 1, 1, 0, 0, 0));
    reset_l = 1'b1;
    tick("rst/after1", ev(0, 0, 1, 1, 0, 0, 0));
    tick("rst/after2", ev(0, 0, 1, 1, 0, 0, 0));

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      ep   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_xfer(kind != 1, kind != 0, 1'($urandom), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ep,
               $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
